// File: rtl/sad_min_search.sv
// Sequential minimum-SAD tracker: scans NUM_CAND candidate SADs in raster order and
// publishes the smallest one with its linear index and row. Optional macro: SAD_EARLY_EXIT_EN.
module sad_min_search #(
    parameter int unsigned SAD_W    = 16,
    parameter int unsigned NUM_CAND = 4096,
    parameter int unsigned ROW_W    = 64
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [SAD_W-1:0] SadIn,
    input  logic             SadValid,
    output logic             Busy,
    output logic             Done,
    output logic [SAD_W-1:0] BestSad,
    output logic [31:0]      BestIndex,
    output logic [31:0]      BestX
);

    localparam int unsigned X_SHIFT  = $clog2(ROW_W);
    localparam logic [31:0] LAST_IDX = 32'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_cnt;
    logic [31:0]      r_idx;
    logic [SAD_W-1:0] r_min;
    logic             w_accept;
    logic             w_take;
    logic             w_final;
    logic [SAD_W-1:0] w_min_next;
    logic [31:0]      w_idx_next;

    // Candidate 0 always loads; later ones need a strict win so ties keep the earliest index.
    always_comb begin
        w_accept   = (r_state == SCAN) && SadValid;
        w_take     = (r_cnt == '0) || (SadIn < r_min);
        w_min_next = w_take ? SadIn : r_min;
        w_idx_next = w_take ? r_cnt : r_idx;
`ifdef SAD_EARLY_EXIT_EN
        w_final    = w_accept && ((r_cnt == LAST_IDX) || (SadIn == '0));
`else
        w_final    = w_accept && (r_cnt == LAST_IDX);
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_state_next = SCAN;
            SCAN:    if (w_final) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == SCAN);
        Done = (r_state == DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt <= '0;
            r_min <= '0;
            r_idx <= '0;
        end else if ((r_state == IDLE) && Start) begin
            r_cnt <= '0;
            r_min <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 32'd1;
            r_min <= w_min_next;
            r_idx <= w_idx_next;
        end
    end

    // Results capture the merged minimum so the final sample takes part in the compare.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            BestSad   <= '0;
            BestIndex <= '0;
            BestX     <= '0;
        end else if (w_final) begin
            BestSad   <= w_min_next;
            BestIndex <= w_idx_next;
            BestX     <= w_idx_next >> X_SHIFT;
        end
    end

endmodule

// File: tb/tb_sad_min_search.sv
// Directed self-checking bench for sad_min_search: a small instance (NUM_CAND=8, ROW_W=4)
// and a default-sized instance share the clock and reset.
module tb_sad_min_search;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        s_start, s_valid;
    logic [15:0] s_sad;
    logic        s_busy, s_done;
    logic [15:0] s_best_sad;
    logic [31:0] s_best_idx, s_best_x;
    logic        b_start, b_valid;
    logic [15:0] b_sad;
    logic        b_busy, b_done;
    logic [15:0] b_best_sad;
    logic [31:0] b_best_idx, b_best_x;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 Clk = ~Clk;

    sad_min_search #(.SAD_W(16), .NUM_CAND(8), .ROW_W(4)) u_small (
        .Clk(Clk), .Rst_n(Rst_n), .Start(s_start), .SadIn(s_sad), .SadValid(s_valid),
        .Busy(s_busy), .Done(s_done), .BestSad(s_best_sad), .BestIndex(s_best_idx),
        .BestX(s_best_x)
    );

    sad_min_search u_big (
        .Clk(Clk), .Rst_n(Rst_n), .Start(b_start), .SadIn(b_sad), .SadValid(b_valid),
        .Busy(b_busy), .Done(b_done), .BestSad(b_best_sad), .BestIndex(b_best_idx),
        .BestX(b_best_x)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Returns on the negedge after the accepting edge.
    task automatic small_start();
        @(negedge Clk);
        s_start = 1'b1;
        @(negedge Clk);
        s_start = 1'b0;
    endtask

    task automatic small_sample(input logic [15:0] v);
        s_valid = 1'b1;
        s_sad   = v;
        @(negedge Clk);
        s_valid = 1'b0;
    endtask

    logic [15:0] tbl [8];
    int unsigned k;
    bit          seen;
    logic [31:0] col;

    initial begin
        Rst_n = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_sad = '0;
        b_start = 1'b0; b_valid = 1'b0; b_sad = '0;
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(s_busy), 0);
        check("rst_done", 32'(s_done), 0);
        check("rst_sad", 32'(s_best_sad), 0);
        check("rst_idx", s_best_idx, 0);
        check("rst_x", s_best_x, 0);
        Rst_n = 1'b1;

        // Basic search 9,7,3,8,3,5,6,4: first 3 wins, index 2.
        tbl = '{16'd9, 16'd7, 16'd3, 16'd8, 16'd3, 16'd5, 16'd6, 16'd4};
        small_start();
        check("t1_busy", 32'(s_busy), 1);
        for (int i = 0; i < 8; i++) begin
            check("t1_nodone", 32'(s_done), 0);
            small_sample(tbl[i]);
        end
        check("t1_done", 32'(s_done), 1);
        check("t1_busy_off", 32'(s_busy), 0);
        check("t1_sad", 32'(s_best_sad), 3);
        check("t1_idx", s_best_idx, 2);
        check("t1_x", s_best_x, 0);
        // Start held through DONE is ignored there, then accepted in IDLE.
        s_start = 1'b1;
        @(negedge Clk);
        check("t1_pulse", 32'(s_done), 0);
        check("t1_idle", 32'(s_busy), 0);
        check("t1_hold", 32'(s_best_sad), 3);
        // Start and SadValid together in IDLE: the zero sample must be discarded.
        s_valid = 1'b1;
        s_sad   = 16'd0;
        @(negedge Clk);
        s_start = 1'b0;
        s_valid = 1'b0;
        check("t5_busy", 32'(s_busy), 1);
        for (int i = 0; i < 8; i++) small_sample(16'hFFFF);
        check("t5_done", 32'(s_done), 1);
        check("t5_sad", 32'(s_best_sad), 32'hFFFF);
        check("t5_idx", s_best_idx, 0);
        @(negedge Clk);

        // Stalled search with a mid-scan Start; minimum 1 at the last index.
        tbl = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd1};
        @(negedge Clk);
        s_start = 1'b1;
        k = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) check("t3_busy", 32'(s_busy), 1);
            s_start = (cyc == 6);
            if (s_done) begin
                seen = 1'b1;
                check("t3_latency", 32'(cyc), 16);
            end else begin
                s_valid = (cyc % 2 == 1) && (k < 8);
                s_sad   = (k < 8) ? tbl[k] : 16'd0;
                if (s_valid) k++;
            end
        end
        s_valid = 1'b0;
        s_start = 1'b0;
        check("t3_seen_done", 32'(seen), 1);
        check("t3_idx", s_best_idx, 7);
        check("t3_sad", 32'(s_best_sad), 1);
        check("t3_x", s_best_x, 1);
        @(negedge Clk);

        // Reset after 4 samples clears everything with no Done.
        small_start();
        for (int i = 0; i < 4; i++) small_sample(16'd20 + 16'(i));
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        check("t4_busy", 32'(s_busy), 0);
        check("t4_done", 32'(s_done), 0);
        check("t4_sad", 32'(s_best_sad), 0);
        check("t4_idx", s_best_idx, 0);
        check("t4_x", s_best_x, 0);
        @(negedge Clk);
        check("t4_nodone", 32'(s_done), 0);
        tbl = '{16'd4, 16'd4, 16'd2, 16'd6, 16'd2, 16'd9, 16'd1, 16'd9};
        small_start();
        for (int i = 0; i < 8; i++) small_sample(tbl[i]);
        check("t4b_done", 32'(s_done), 1);
        check("t4b_sad", 32'(s_best_sad), 1);
        check("t4b_idx", s_best_idx, 6);
        check("t4b_x", s_best_x, 1);
        @(negedge Clk);

`ifdef SAD_EARLY_EXIT_EN
        // A zero SAD ends the scan at once; later samples are ignored.
        small_start();
        small_sample(16'd5);
        small_sample(16'd0);
        check("t6_done", 32'(s_done), 1);
        check("t6_sad", 32'(s_best_sad), 0);
        check("t6_idx", s_best_idx, 1);
        small_sample(16'd2);
        small_sample(16'd1);
        check("t6_idle", 32'(s_busy), 0);
        check("t6_hold", s_best_idx, 1);
`endif

        // Default size: 1000 everywhere except index 130 -> column 2 downstream.
        @(negedge Clk);
        b_start = 1'b1;
        @(negedge Clk);
        b_start = 1'b0;
        check("t2_busy", 32'(b_busy), 1);
        for (int i = 0; i < 4096; i++) begin
            b_valid = 1'b1;
            b_sad   = (i == 130) ? 16'd12 : 16'd1000;
            @(negedge Clk);
        end
        b_valid = 1'b0;
        check("t2_done", 32'(b_done), 1);
        check("t2_sad", 32'(b_best_sad), 12);
        check("t2_idx", b_best_idx, 130);
        check("t2_x", b_best_x, 2);
        col = b_best_idx - (b_best_x << 6);
        check("t2_col", col, 2);
        @(negedge Clk);
        check("t2_pulse", 32'(b_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
